// File: rtl/muldiv_pkg.sv
// Shared types and decode constants for the RV32M multiply/divide unit.
// Holds the FSM state encoding, the Funct3 op encodings and the R-type/M-extension match values.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 unsigned shift-add multiplier / restoring divider on a 2*XLEN accumulator.
// Latency: one step per cycle while step=1, XLEN steps per operation; no backpressure, the owner sequences load/step.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   magA,
    input  logic [XLEN-1:0]   magB,
    output logic [2*XLEN-1:0] acc
);

    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] acc_nxt;

    // mul: acc = {partial product, remaining multiplier bits}
    // div: acc = {partial remainder, dividend bits shifting into quotient}
    always_comb begin
        addend  = acc[0] ? magA : '0;
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
        rem_sh  = acc[2*XLEN-1:XLEN-1];
        diff    = rem_sh - {1'b0, magB};
        acc_nxt = {mul_sum, acc[XLEN-1:1]};
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (load) begin
            acc <= is_div ? {{XLEN{1'b0}}, magA} : {{XLEN{1'b0}}, magB};
        end else if (step) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// EX-stage RV32M decode, FSM, sign fixup and pipeline stall handshake around the iterative core.
// Latency: XLEN+2 cycles from accept (1 for div special cases); stalls the pipeline until the result pulse.
module alu_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            is_muldiv,
    output logic            stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] Result
);

    localparam int                CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   XMIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state, state_nxt;
    md_op_t            op, op_in;
    logic [CNT_W-1:0]  count;
    logic              neg;
    logic [XLEN-1:0]   result_r;

    logic              accept, core_load, core_step;
    logic              sa, sb, neg_in, div_zero, div_ovf, special;
    logic [XLEN-1:0]   mag_a, mag_b, special_res, fix_res, div_val;
    logic [2*XLEN-1:0] acc, prod;

    assign op_in     = md_op_t'(Funct3);
    assign is_muldiv = (ALUOp == ALUOP_RTYPE) && (Funct7 == FUNCT7_MULDIV);

    // Operand signs: MULHSU treats only rs1 as signed
    always_comb begin
        sa     = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && SrcA[XLEN-1];
        sb     = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && SrcB[XLEN-1];
        mag_a  = sa ? (~SrcA + 1'b1) : SrcA;
        mag_b  = sb ? (~SrcB + 1'b1) : SrcB;
        neg_in = sa ^ sb;
        case (op_in)
            OP_MULHU, OP_DIVU, OP_REMU: neg_in = 1'b0;
            OP_MULHSU, OP_REM:          neg_in = sa;
            default:                    neg_in = sa ^ sb;
        endcase
    end

    always_comb begin
        div_zero    = Funct3[2] && (SrcB == '0);
        div_ovf     = (op_in == OP_DIV || op_in == OP_REM) && (SrcA == XMIN) && (SrcB == '1);
        special     = div_zero || div_ovf;
        special_res = Funct3[1] ? '0 : XMIN;
        if (div_zero) begin
            special_res = Funct3[1] ? SrcA : '1;
        end
    end

    always_comb begin
        prod    = neg ? (~acc + 1'b1) : acc;
        div_val = (op == OP_REM || op == OP_REMU) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (neg) begin
            div_val = ~div_val + 1'b1;
        end
        case (op)
            OP_MUL:                       fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            default:                      fix_res = div_val;
        endcase
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_muldiv && !flush) begin
                    accept    = 1'b1;
                    core_load = 1'b1;
                    state_nxt = special ? DONE : RUN;
                end
            end
            RUN: begin
                core_step = 1'b1;
                if (count == LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op       <= OP_MUL;
            count    <= '0;
            neg      <= 1'b0;
            result_r <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op    <= op_in;
                neg   <= neg_in;
                count <= '0;
                if (special) begin
                    result_r <= special_res;
                end
            end else if (state == RUN) begin
                count <= count + 1'b1;
            end
            if (state == FIX) begin
                result_r <= fix_res;
            end
        end
    end

    muldiv_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (core_load),
        .step   (core_step),
        .is_div (accept ? Funct3[2] : op[2]),
        .magA   (mag_a),
        .magB   (mag_b),
        .acc    (acc)
    );

    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE) && !flush;
    assign Result       = result_r;
    assign stall        = start && is_muldiv && !result_valid && !flush;

    // EX must hold its instruction until the result pulse unless it is killed
    a_start_held: assert property (@(posedge clk) disable iff (reset) (busy && !flush) |-> start);

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Bench for alu_muldiv_unit: directed RV32M cases plus randomized ops against an arithmetic reference model.
module tb_alu_muldiv_unit;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [1:0]  ALUOp;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic        is_muldiv, stall, busy, result_valid;
    logic [31:0] Result;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    alu_muldiv_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .flush        (flush),
        .ALUOp        (ALUOp),
        .Funct7       (Funct7),
        .Funct3       (Funct3),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .is_muldiv    (is_muldiv),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .Result       (Result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] as, bs, ub, p;
        logic        [63:0] up;
        logic signed [31:0] sa, sb;
        as = {{32{a[31]}}, a};
        bs = {{32{b[31]}}, b};
        ub = {32'b0, b};
        sa = a;
        sb = b;
        case (f3)
            3'b000: begin p = as * bs; return p[31:0]; end
            3'b001: begin p = as * bs; return p[63:32]; end
            3'b010: begin p = as * ub; return p[63:32]; end
            3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Presents one M instruction and holds it until the result pulse; returns cycle offset and absolute cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit stall_ok, output int vcyc);
        res = '0; lat = -1; stall_ok = 1'b1; vcyc = 0;
        start = 1'b1; flush = 1'b0; ALUOp = 2'b10; Funct7 = 7'b0000001;
        Funct3 = f3; SrcA = a; SrcB = b;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                res = Result; lat = c; vcyc = cyc;
                if (stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (lat < 0) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res, exp_res;
        int lat, exp_lat, vc;
        bit sok;
        exp_res = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        run_op(f3, a, b, res, lat, sok, vc);
        vectors++;
        if (res !== exp_res || lat != exp_lat) begin
            miscompares++;
            $display("FAIL %s f3=%0d a=%h b=%h: got result %h at cycle %0d, expected %h at cycle %0d",
                     name, f3, a, b, res, lat, exp_res, exp_lat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        ALUOp = 2'b00; Funct7 = 7'b0; Funct3 = 3'b0; SrcA = '0; SrcB = '0;
        #2;
        vectors++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || Result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b valid=%b result=%h, expected 0/0/0", busy, result_valid, Result);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_mul_timing();
        logic [31:0] res;
        int lat, vc;
        bit sok;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, res, lat, sok, vc);
        vectors++;
        if (res !== 32'hFFFF_FFEB || lat != 34 || !sok) begin
            miscompares++;
            $display("FAIL mul_timing: result=%h cycle=%0d stall_ok=%b, expected ffffffeb cycle 34 stall_ok 1", res, lat, sok);
        end
    endtask

    task automatic test_mulh();
        check_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    task automatic test_div();
        check_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2);
        check_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2);
        check_op("divu", 3'b101, 32'd100, 32'd7);
        check_op("remu", 3'b111, 32'd100, 32'd7);
    endtask

    task automatic test_div_special();
        check_op("divu_zero", 3'b101, 32'd5, 32'd0);
        check_op("remu_zero", 3'b111, 32'd5, 32'd0);
        check_op("div_zero", 3'b100, 32'hFFFF_FFF0, 32'd0);
        check_op("rem_zero", 3'b110, 32'hFFFF_FFF0, 32'd0);
        check_op("div_ovf", 3'b100, MIN32, 32'hFFFF_FFFF);
        check_op("rem_ovf", 3'b110, MIN32, 32'hFFFF_FFFF);
    endtask

    task automatic test_flush();
        bit seen;
        start = 1'b1; flush = 1'b0; ALUOp = 2'b10; Funct7 = 7'b0000001;
        Funct3 = 3'b100; SrcA = 32'd1000; SrcB = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        seen = (result_valid !== 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_busy: busy=%b at cycle 11, expected 0", busy);
        end
        for (int i = 0; i < 40; i++) begin
            if (result_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL flush_no_valid: result_valid seen=1, expected 0");
        end
        @(posedge clk); #1;
        check_op("mul_after_flush", 3'b000, 32'd3, 32'd4);
    endtask

    task automatic test_async_reset();
        start = 1'b1; flush = 1'b0; ALUOp = 2'b10; Funct7 = 7'b0000001;
        Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd9;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1; start = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || Result !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b valid=%b result=%h, expected 0/0/0", busy, result_valid, Result);
        end
        #2 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_non_m();
        bit bad;
        bad = 1'b0;
        start = 1'b1; flush = 1'b0; ALUOp = 2'b10; Funct7 = 7'b0000000;
        Funct3 = 3'b000; SrcA = 32'd5; SrcB = 32'd6;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (is_muldiv !== 1'b0 || stall !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL non_m_add: is_muldiv=%b stall=%b busy=%b, expected 0/0/0", is_muldiv, stall, busy);
        end
        ALUOp = 2'b00; Funct7 = 7'b0000001;
        @(negedge clk);
        vectors++;
        if (is_muldiv !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL non_rtype: is_muldiv=%b stall=%b, expected 0/0", is_muldiv, stall);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        int l1, l2, v1, v2;
        bit s1, s2;
        run_op(3'b000, 32'd11, 32'd13, r1, l1, s1, v1);
        run_op(3'b000, 32'hFFFF_FFFE, 32'd21, r2, l2, s2, v2);
        vectors++;
        if (r1 !== 32'd143 || r2 !== 32'hFFFF_FFD6 || (v2 - v1) != 35) begin
            miscompares++;
            $display("FAIL back_to_back: results %h %h spacing %0d, expected 0000008f ffffffd6 spacing 35", r1, r2, v2 - v1);
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int i = 0; i < 48; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = MIN32; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            check_op("random", f3, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_mulh();
        test_div();
        test_div_special();
        test_flush();
        test_async_reset();
        test_non_m();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
